// File: rtl/sram_controller.sv
// Splits 32-bit loads/stores into two 16-bit async SRAM accesses of WAIT_CYCLES each; 2*WAIT_CYCLES+2 cycles per access.
// ready drops combinationally as soon as a request appears and returns high for the single DONE cycle.
module sram_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] sram_dq,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(ADDR_BASE);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last;
  logic        in_acc;
  logic        is_wr_q;
  logic [16:0] word_d, word_q;
  logic [31:0] wdata_q;
  logic [15:0] lo_hold;
  logic [15:0] dq_dat;
  logic        dq_oe;

  // Out-of-range addresses wrap: only 17 word-address bits reach the pins.
  assign word_d = 17'((address - BASE) >> 2);
  assign last   = (cnt == LAST_CNT);
  assign in_acc = (state == LO) || (state == HI);

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = !(wr_en | rd_en);
        if (wr_en | rd_en) state_nxt = LO;
      end
      LO:      if (last) state_nxt = HI;
      HI:      if (last) state_nxt = DONE;
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // we_n releases on the last cycle of each half so data is held past the write edge.
  always_comb begin
    sram_addr = in_acc ? {word_q, state == HI} : 18'd0;
    sram_we_n = !(in_acc && is_wr_q && !last);
    sram_oe_n = !(in_acc && !is_wr_q);
    sram_ce_n = !in_acc;
    sram_ub_n = !in_acc;
    sram_lb_n = !in_acc;
    dq_oe     = in_acc && is_wr_q;
    dq_dat    = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
  end

  assign sram_dq = dq_oe ? dq_dat : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      read_data <= 32'd0;
      lo_hold   <= 16'd0;
      word_q    <= 17'd0;
      wdata_q   <= 32'd0;
      is_wr_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || !in_acc)
        cnt <= 4'd0;
      else
        cnt <= cnt + 4'd1;
      if (state == IDLE && (wr_en | rd_en)) begin
        word_q  <= word_d;
        wdata_q <= write_data;
        is_wr_q <= wr_en;
      end
      if (state == LO && last && !is_wr_q)
        lo_hold <= sram_dq;
      if (state == HI && last && !is_wr_q)
        read_data <= {sram_dq, lo_hold};
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: per-cycle model check of all outputs plus hand-computed pins.
// Stimulus is cycle-counted, so the run always terminates.
module tb_sram_controller;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;
  localparam logic [31:0] A2   = 32'd525332;  // 1024 + 4*(2^17 + 5): wraps onto word 5

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  always #5 clk = ~clk;

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(we_n), .sram_oe_n(oe_n),
    .sram_ce_n(ce_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
  );

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu (sram_dq[i]);
  end

  // External SRAM model
  logic [15:0] mem [0:511];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[8:0]] : 16'hzzzz;
  always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr[8:0]] <= sram_dq;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          act = 1'b0;
  bit          chk_on = 1'b0;
  int          t0;
  bit          tx_wr;
  logic [31:0] tx_addr, tx_data;
  logic [31:0] exp_rd;
  logic [31:0] shadow [int];

  logic        ready_log [0:1023];
  logic        we_log    [0:1023];
  logic        ce_log    [0:1023];
  logic [17:0] addr_log  [0:1023];
  logic [15:0] dq_log    [0:1023];
  logic [31:0] rd_log    [0:1023];

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  // Model: output values follow from the cycle offset k since the request first appeared.
  initial begin
    int          k;
    bit          lo, hi, acc;
    logic [31:0] word;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        k    = act ? cyc - t0 : -1;
        lo   = act && k >= 1 && k <= W;
        hi   = act && k >= W + 1 && k <= 2 * W;
        acc  = lo || hi;
        word = ((tx_addr - BASE) >> 2) & 32'h1FFFF;
        if (act && k == 2 * W + 1) begin
          if (tx_wr) shadow[int'(word)] = tx_data;
          else       exp_rd = shadow.exists(int'(word)) ? shadow[int'(word)] : 32'd0;
        end
        chk("ready", ready, act ? (k == 2 * W + 1) : !(rd_en || wr_en));
        chk("ce_n", ce_n, !acc);
        chk("ub_n", ub_n, !acc);
        chk("lb_n", lb_n, !acc);
        chk("oe_n", oe_n, !(acc && !tx_wr));
        chk("we_n", we_n, !(acc && tx_wr && k != W && k != 2 * W));
        chk("sram_addr", sram_addr, acc ? word * 2 + 32'(hi) : 32'd0);
        if (!(acc && !tx_wr))
          chk("sram_dq", sram_dq, acc ? (hi ? tx_data[31:16] : tx_data[15:0]) : 16'hFFFF);
        chk("read_data", read_data, exp_rd);
        if (cyc < 1024) begin
          ready_log[cyc] = ready;  we_log[cyc] = we_n;  ce_log[cyc] = ce_n;
          addr_log[cyc]  = sram_addr;  dq_log[cyc] = sram_dq;  rd_log[cyc] = read_data;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    wr_en = wr;  rd_en = rd;  address = a;  write_data = d;
    act = 1'b1;  t0 = cyc;  tx_wr = wr;  tx_addr = a;  tx_data = d;
  endtask

  task automatic go_idle;
    wr_en = 1'b0;  rd_en = 1'b0;  act = 1'b0;
  endtask

  task automatic run_access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                            output int ts);
    start(wr, rd, a, d);
    ts = t0;
    repeat (2 * W + 2) tick;
    go_idle;
  endtask

  initial begin
    int          ts, c;
    logic [11:0] pat;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    rst = 1'b1;  wr_en = 1'b0;  rd_en = 1'b0;  address = 32'd0;  write_data = 32'd0;
    exp_rd = 32'd0;  tx_wr = 1'b0;  tx_addr = BASE;  tx_data = 32'd0;  t0 = 0;
    tick;
    chk_on = 1'b1;
    tick;
    rst = 1'b0;
    repeat (2) tick;

    // Store 0xDEADBEEF at 1028 -> SRAM halfwords 2 and 3
    run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, ts);
    tick;
    chk("st_lo_addr", addr_log[ts + 1], 18'd2);
    chk("st_lo_dq", dq_log[ts + 1], 16'hBEEF);
    chk("st_we_c1", we_log[ts + 1], 1'b0);
    chk("st_we_c2", we_log[ts + 2], 1'b1);
    chk("st_hi_addr", addr_log[ts + 3], 18'd3);
    chk("st_hi_dq", dq_log[ts + 3], 16'hDEAD);
    pat = 12'd0;
    for (int i = 0; i < 6; i++) pat[i] = ready_log[ts + i];
    chk("st_ready_pat", 32'(pat), 32'b10_0000);

    // Load it back
    run_access(1'b0, 1'b1, 32'd1028, 32'd0, ts);
    tick;
    chk("ld_rdata", rd_log[ts + 5], 32'hDEADBEEF);

    // rd_en & wr_en together is a store; read_data keeps its value
    run_access(1'b1, 1'b1, 32'd1032, 32'h12345678, ts);
    tick;
    chk("both_rdata", rd_log[ts + 5], 32'hDEADBEEF);
    chk("both_we", we_log[ts + 1], 1'b0);

    // Back-to-back: load, then a store presented during DONE at a wrapping address
    start(1'b0, 1'b1, 32'd1032, 32'd0);
    ts = t0;
    repeat (2 * W + 1) tick;
    wr_en = 1'b1;  rd_en = 1'b0;  address = A2;  write_data = 32'hCAFEF00D;
    tick;
    start(1'b1, 1'b0, A2, 32'hCAFEF00D);
    repeat (2 * W + 2) tick;
    go_idle;
    tick;
    for (int i = 0; i < 12; i++) pat[i] = ready_log[ts + i];
    chk("b2b_ready_pat", 32'(pat), 32'b1000_0010_0000);
    chk("b2b_rdata", rd_log[ts + 5], 32'h12345678);
    chk("b2b_idle_ce", ce_log[ts + 6], 1'b1);
    chk("b2b_lo_addr", addr_log[ts + 7], 18'd10);

    // Word 5 via its in-range alias sees the wrapped store
    run_access(1'b0, 1'b1, 32'd1044, 32'd0, ts);
    tick;
    chk("wrap_rdata", rd_log[ts + 5], 32'hCAFEF00D);

    // Address below base wraps to the top word; reset mid-write in cycle 3
    start(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A);
    ts = t0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    go_idle;
    exp_rd = 32'd0;
    c = cyc;
    @(negedge clk);
    #1;
    chk("neg_lo_addr", addr_log[ts + 1], 18'h3FFFE);
    chk("rst_ready", ready_log[c], 1'b1);
    chk("rst_ce", ce_log[c], 1'b1);
    chk("rst_rdata", rd_log[c], 32'd0);
    chk("rst_dq", dq_log[c], 16'hFFFF);
    repeat (3) tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
